quad_step_decoder: RTL and testbench

- Upstream front end for the 4-bit up/down counter.
- Takes raw quadrature signals (A/B) from a rotary encoder or board switches. Synchronises and glitch-filters them, then decodes the Gray-code sequence.
- Produces a single-cycle step pulse plus a direction level `t` (1 = up, 0 = down) that map directly onto the counter's enable and direction inputs.
- Flags illegal double-bit transitions.

---
 rtl/quad_step_decoder_pkg.sv | 50 +++++
 rtl/quad_step_decoder_filter.sv | 42 ++++
 rtl/quad_step_decoder.sv | 109 ++++++++++
 tb/tb_quad_step_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_step_decoder_pkg.sv
// Shared definitions for the quadrature step decoder: state encodings,
// direction levels and the Gray-code transition classifier.
package quad_step_decoder_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_10 = 2'b10;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_01 = 2'b01;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int CNT_W = 4;
  localparam int ACC_W = 4;

  typedef enum logic [1:0] {
    MV_NONE,
    MV_UP,
    MV_DN,
    MV_ILLEGAL
  } move_t;

  // Successor of a state when turning in the up direction.
  function automatic logic [1:0] next_up(input logic [1:0] qs);
    logic [1:0] nxt;
    nxt = QS_00;
    case (qs)
      QS_00:   nxt = QS_10;
      QS_10:   nxt = QS_11;
      QS_11:   nxt = QS_01;
      QS_01:   nxt = QS_00;
      default: nxt = QS_00;
    endcase
    return nxt;
  endfunction

  function automatic move_t classify_move(input logic [1:0] prev, input logic [1:0] cur);
    move_t mv;
    if (cur == prev)
      mv = MV_NONE;
    else if ((cur ^ prev) == 2'b11)
      mv = MV_ILLEGAL;
    else if (cur == next_up(prev))
      mv = MV_UP;
    else
      mv = MV_DN;
    return mv;
  endfunction

endpackage

// File: rtl/quad_step_decoder_filter.sv
// One quadrature channel: two-flop synchroniser followed by a stability
// counter that only accepts a level held for FILTER_LEN consecutive cycles.
module quad_input_filter
  import quad_step_decoder_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic filt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the sync chain two stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      filt  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front end: filters A/B, decodes Gray-code motion and emits one
// step pulse (with direction t) per detent, plus an error pulse on double-bit moves.
module quad_step_decoder
  import quad_step_decoder_pkg::*;
#(
  parameter int FILTER_LEN       = 4,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       en,
  output logic       step,
  output logic       t,
  output logic       err,
  output logic [1:0] ab_state
);

  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("quad_step_decoder: FILTER_LEN must be 1..15");
  end
  if (STEPS_PER_DETENT != 1 && STEPS_PER_DETENT != 2 && STEPS_PER_DETENT != 4) begin : g_bad_spd
    $error("quad_step_decoder: STEPS_PER_DETENT must be 1, 2 or 4");
  end

  localparam logic signed [ACC_W-1:0] ACC_POS = ACC_W'(STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0] ACC_NEG = ACC_W'(-STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  logic                    filt_a;
  logic                    filt_b;
  logic [1:0]              cur;
  logic [1:0]              prev;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_inc;
  logic signed [ACC_W-1:0] acc_dec;
  move_t                   mv;

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .din  (a_in),
    .filt (filt_a)
  );

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .din  (b_in),
    .filt (filt_b)
  );

  assign cur      = {filt_a, filt_b};
  assign ab_state = cur;

  // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
  always_comb begin
    mv      = classify_move(prev, cur);
    acc_inc = acc + ACC_ONE;
    acc_dec = acc - ACC_ONE;
  end

  // prev tracks cur even while disabled, so re-enabling never sees a stale jump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= QS_00;
      acc  <= '0;
      step <= 1'b0;
      err  <= 1'b0;
      t    <= DIR_UP;
    end else begin
      prev <= cur;
      step <= 1'b0;
      err  <= 1'b0;
      if (!en) begin
        acc <= '0;
      end else begin
        case (mv)
          MV_UP: begin
            if (acc_inc == ACC_POS) begin
              step <= 1'b1;
              t    <= DIR_UP;
              acc  <= '0;
            end else begin
              acc <= acc_inc;
            end
          end
          MV_DN: begin
            if (acc_dec == ACC_NEG) begin
              step <= 1'b1;
              t    <= DIR_DN;
              acc  <= '0;
            end else begin
              acc <= acc_dec;
            end
          end
          MV_ILLEGAL: begin
            err <= 1'b1;
            acc <= '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: a default instance and a fast one-step-per-
// transition instance, both tracked every cycle by a window/position model.
module tb_quad_step_decoder;

  localparam int FL0  = 4;
  localparam int SPD0 = 4;
  localparam int FL1  = 2;
  localparam int SPD1 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a0 = 1'b0, b0 = 1'b0, en0 = 1'b1;
  logic       a1 = 1'b0, b1 = 1'b0, en1 = 1'b1;
  logic       step0, t0, err0, step1, t1, err1;
  logic [1:0] ab0, ab1;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  quad_step_decoder #(.FILTER_LEN(FL0), .STEPS_PER_DETENT(SPD0)) dut0 (
    .clk(clk), .rst(rst), .a_in(a0), .b_in(b0), .en(en0),
    .step(step0), .t(t0), .err(err0), .ab_state(ab0)
  );

  quad_step_decoder #(.FILTER_LEN(FL1), .STEPS_PER_DETENT(SPD1)) dut1 (
    .clk(clk), .rst(rst), .a_in(a1), .b_in(b1), .en(en1),
    .step(step1), .t(t1), .err(err1), .ab_state(ab1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples reach the filter two edges late; a filtered
  // level flips once the last FL samples all disagree with it; motion is the
  // difference of positions around the 4-state ring.
  typedef struct {
    logic [1:0]  ra, rb;
    logic [15:0] ha, hb;
    logic        fa, fb;
    logic [1:0]  prev;
    int          net;
    logic        step, err, t;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.ra = '0; m.rb = '0; m.ha = '0; m.hb = '0;
    m.fa = 1'b0; m.fb = 1'b0; m.prev = 2'b00; m.net = 0;
    m.step = 1'b0; m.err = 1'b0; m.t = 1'b1;
    return m;
  endfunction

  function automatic int ring_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic window_filter(input logic f, input logic [15:0] h, input int fl);
    logic [15:0] mask;
    mask = 16'((1 << fl) - 1);
    if (f) return ((h & mask) == 16'd0) ? 1'b0 : 1'b1;
    return ((h & mask) == mask) ? 1'b1 : 1'b0;
  endfunction

  function automatic model_t model_next(input model_t m, input logic a, input logic b,
                                        input logic e, input int fl, input int spd);
    model_t n;
    int     d;
    n = m;
    n.step = 1'b0;
    n.err  = 1'b0;
    d = (ring_pos({m.fa, m.fb}) - ring_pos(m.prev) + 4) % 4;
    if (!e) begin
      n.net = 0;
    end else if (d == 2) begin
      n.err = 1'b1;
      n.net = 0;
    end else if (d != 0) begin
      n.net = m.net + ((d == 1) ? 1 : -1);
      if (n.net == spd) begin
        n.step = 1'b1; n.t = 1'b1; n.net = 0;
      end else if (n.net == -spd) begin
        n.step = 1'b1; n.t = 1'b0; n.net = 0;
      end
    end
    n.prev = {m.fa, m.fb};
    n.ha = {m.ha[14:0], m.ra[1]};
    n.hb = {m.hb[14:0], m.rb[1]};
    n.fa = window_filter(m.fa, n.ha, fl);
    n.fb = window_filter(m.fb, n.hb, fl);
    n.ra = {m.ra[0], a};
    n.rb = {m.rb[0], b};
    return n;
  endfunction

  model_t m0, m1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= model_reset();
      m1 <= model_reset();
    end else begin
      m0 <= model_next(m0, a0, b0, en0, FL0, SPD0);
      m1 <= model_next(m1, a1, b1, en1, FL1, SPD1);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cycle_dut0", 32'({step0, err0, t0, ab0}), 32'({m0.step, m0.err, m0.t, m0.fa, m0.fb}));
      check("cycle_dut1", 32'({step1, err1, t1, ab1}), 32'({m1.step, m1.err, m1.t, m1.fa, m1.fb}));
    end
  end

  // Caller sits on a negedge; the level is applied there and sample i is taken after edge i.
  task automatic drive_level(input int d, input logic a, input logic b, input int hold,
                             output int ns, output int ne, output int first);
    ns = 0; ne = 0; first = 0;
    if (d == 0) begin a0 = a; b0 = b; end
    else begin a1 = a; b1 = b; end
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (((d == 0) ? step0 : step1) === 1'b1) begin
        ns++;
        if (first == 0) first = i;
      end
      if (((d == 0) ? err0 : err1) === 1'b1) ne++;
    end
  endtask

  typedef struct {
    logic       a, b;
    int         hold, steps, errs, step_at;
    logic       t;
    logic [1:0] ab;
  } vec_t;

  initial begin
    vec_t       tbl [27];
    int         ns, ne, first;
    logic [1:0] lv0, lv1;

    //          a     b     hold st er at  t     ab
    tbl[0]  = '{1'b0, 1'b0, 50, 0, 0, 0, 1'b1, 2'b00};
    tbl[1]  = '{1'b1, 1'b0, 10, 0, 0, 0, 1'b1, 2'b10};
    tbl[2]  = '{1'b1, 1'b1, 10, 0, 0, 0, 1'b1, 2'b11};
    tbl[3]  = '{1'b0, 1'b1, 10, 0, 0, 0, 1'b1, 2'b01};
    tbl[4]  = '{1'b0, 1'b0, 10, 1, 0, 7, 1'b1, 2'b00};
    tbl[5]  = '{1'b0, 1'b1, 10, 0, 0, 0, 1'b1, 2'b01};
    tbl[6]  = '{1'b1, 1'b1, 10, 0, 0, 0, 1'b1, 2'b11};
    tbl[7]  = '{1'b1, 1'b0, 10, 0, 0, 0, 1'b1, 2'b10};
    tbl[8]  = '{1'b0, 1'b0, 10, 1, 0, 7, 1'b0, 2'b00};
    tbl[9]  = '{1'b0, 1'b1, 10, 0, 0, 0, 1'b0, 2'b01};
    tbl[10] = '{1'b1, 1'b1, 10, 0, 0, 0, 1'b0, 2'b11};
    tbl[11] = '{1'b1, 1'b0, 10, 0, 0, 0, 1'b0, 2'b10};
    tbl[12] = '{1'b0, 1'b0, 10, 1, 0, 7, 1'b0, 2'b00};
    tbl[13] = '{1'b1, 1'b0,  3, 0, 0, 0, 1'b0, 2'b00};
    tbl[14] = '{1'b0, 1'b0, 20, 0, 0, 0, 1'b0, 2'b00};
    tbl[15] = '{1'b1, 1'b0, 10, 0, 0, 0, 1'b0, 2'b10};
    tbl[16] = '{1'b0, 1'b1, 10, 0, 1, 0, 1'b0, 2'b01};
    tbl[17] = '{1'b0, 1'b0, 10, 0, 0, 0, 1'b0, 2'b00};
    tbl[18] = '{1'b1, 1'b0, 10, 0, 0, 0, 1'b0, 2'b10};
    tbl[19] = '{1'b1, 1'b1, 10, 0, 0, 0, 1'b0, 2'b11};
    tbl[20] = '{1'b0, 1'b1, 10, 1, 0, 7, 1'b1, 2'b01};
    tbl[21] = '{1'b0, 1'b0, 10, 0, 0, 0, 1'b1, 2'b00};
    tbl[22] = '{1'b1, 1'b1, 10, 0, 1, 0, 1'b1, 2'b11};
    tbl[23] = '{1'b0, 1'b1, 10, 0, 0, 0, 1'b1, 2'b01};
    tbl[24] = '{1'b0, 1'b0, 10, 0, 0, 0, 1'b1, 2'b00};
    tbl[25] = '{1'b1, 1'b0, 10, 0, 0, 0, 1'b1, 2'b10};
    tbl[26] = '{1'b1, 1'b1, 10, 1, 0, 7, 1'b1, 2'b11};

    #1 rst = 1'b1;
    #2;
    check("reset_dut0", 32'({step0, err0, t0, ab0}), 32'({1'b0, 1'b0, 1'b1, 2'b00}));
    check("reset_dut1", 32'({step1, err1, t1, ab1}), 32'({1'b0, 1'b0, 1'b1, 2'b00}));
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      drive_level(0, tbl[i].a, tbl[i].b, tbl[i].hold, ns, ne, first);
      check($sformatf("vec%0d_steps", i), ns, tbl[i].steps);
      check($sformatf("vec%0d_errs", i), ne, tbl[i].errs);
      check($sformatf("vec%0d_t", i), 32'(t0), 32'(tbl[i].t));
      check($sformatf("vec%0d_ab", i), 32'(ab0), 32'(tbl[i].ab));
      if (tbl[i].step_at != 0)
        check($sformatf("vec%0d_step_edge", i), first, tbl[i].step_at);
    end

    // One step per transition: enable gating, then reset in mid-motion.
    drive_level(1, 1'b0, 1'b1, 10, ns, ne, first);
    check("spd1_down_steps", ns, 1);
    check("spd1_down_t", 32'(t1), 32'(1'b0));
    en1 = 1'b0;
    drive_level(1, 1'b0, 1'b0, 10, ns, ne, first);
    check("spd1_dis1_steps", ns + ne, 0);
    drive_level(1, 1'b1, 1'b0, 10, ns, ne, first);
    check("spd1_dis2_steps", ns + ne, 0);
    check("spd1_dis_t", 32'(t1), 32'(1'b0));
    check("spd1_dis_ab", 32'(ab1), 32'(2'b10));
    en1 = 1'b1;
    drive_level(1, 1'b1, 1'b1, 10, ns, ne, first);
    check("spd1_reen_steps", ns, 1);
    check("spd1_reen_errs", ne, 0);
    check("spd1_reen_t", 32'(t1), 32'(1'b1));
    drive_level(1, 1'b1, 1'b0, 10, ns, ne, first);
    check("spd1_down2_t", 32'(t1), 32'(1'b0));

    a1 = 1'b1; b1 = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", 32'({step1, err1, t1, ab1}), 32'({1'b0, 1'b0, 1'b1, 2'b00}));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive_level(1, 1'b1, 1'b1, 10, ns, ne, first);
    check("postrst_errs", ne, 1);
    check("postrst_steps", ns, 0);
    check("postrst_ab", 32'(ab1), 32'(2'b11));

    for (int k = 0; k < 300; k++) begin
      lv0 = 2'($urandom_range(0, 3));
      lv1 = 2'($urandom_range(0, 3));
      {a0, b0} = lv0;
      {a1, b1} = lv1;
      en0 = ($urandom_range(0, 7) != 0);
      en1 = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
